tlc_phase_arbiter: RTL and testbench
====================================

# tlc_phase_arbiter

Green-phase scheduler for the 5-phase intersection. It latches raw traffic-sensor requests per phase as sticky pending bits. It picks the next phase to serve, using round-robin with emergency preemption, and hands that phase to the downstream phase sequencer over a valid/ready handshake. It then waits for the sequencer to report that the phase has finished its yellow and all-red before it picks again. It sits between the sensor inputs and the light-sequencing FSM, and it owns the rule for which direction gets the intersection next.

## Interface
Parameters:
- NPH, 5, number of phases. Index map: 0=ES+WS, 1=ES+EL, 2=WS+WL, 3=EL+WL, 4=NS.
- PW, 3, width of a phase index; must satisfy 2**PW >= NPH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- sensor  in  NPH  raw per-phase traffic request, level.
- preempt  in  1  emergency-vehicle request, level.
- preempt_phase  in  PW  phase the emergency vehicle needs; values >= NPH are invalid.
- grant_valid  out  1  offer of grant_phase to the sequencer.
- grant_phase  out  PW  phase being offered or served.
- grant_ready  in  1  sequencer accepts the offer.
- phase_done  in  1  one-cycle pulse: the served phase has completed its all-red.
- abort  out  1  asks the sequencer to cut the current green short and go to yellow.
- pending  out  NPH  latched outstanding requests.
- busy  out  1  high in OFFER or ACTIVE.

## Operation
- Preempt qualification: pv = preempt && (preempt_phase < NPH). If preempt_phase is invalid, preempt is ignored.
- FSM states are IDLE, OFFER and ACTIVE. Register last_phase resets to NPH-1.
- Pending register update, every edge: pending <= (pending | sensor_mask) & ~clr.
  - sensor_mask is sensor, except that in ACTIVE the bit of grant_phase is masked to 0; that phase is already being served.
  - clr is onehot(grant_phase) on an accept edge (OFFER && grant_ready), otherwise 0.
  - When set and clear hit the same bit, clear wins.
- Selection (combinational, from the registered pending):
  - If pv, select preempt_phase.
  - Otherwise select the first set pending bit, searching from last_phase+1 upward and wrapping modulo NPH.
  - last_phase itself is checked last.
- IDLE:
  - If pv or |pending: register the selection into grant_phase and go to OFFER.
  - Otherwise stay in IDLE.
- OFFER:
  - grant_valid=1.
  - grant_phase stays stable until accepted, even if preempt or pending change meanwhile.
  - grant_ready=1: go to ACTIVE, last_phase <= grant_phase, clear that pending bit.
  - phase_done is ignored in this state.
- ACTIVE:
  - grant_valid=0; grant_phase holds the served phase.
  - If pv && preempt_phase != grant_phase: set abort. abort stays high even if preempt drops.
  - phase_done: go to IDLE and clear abort. phase_done wins over an abort set condition on the same edge.
- phase_done arriving in IDLE or OFFER is ignored.
- Reset, including mid-operation, forces:
  - state IDLE, grant_valid 0, grant_phase 0, abort 0, pending 0, busy 0, last_phase NPH-1.
  - Any handshake in progress is dropped.

## Timing
- All outputs are registered, or decoded from registered state only. There are no combinational input-to-output paths.
- Request path: sensor[i] high at edge E0 makes pending[i]=1 after E0. From IDLE, grant_valid=1 after E1, a latency of 2 edges.
- Preempt path: preempt high at edge E0 while in IDLE gives grant_valid=1 after E0, a latency of 1 edge.
- Handshake: the transfer happens on the edge where grant_valid && grant_ready. The earliest next offer is 2 edges after phase_done: IDLE, then OFFER.
- Abort: asserted 1 edge after pv with a conflicting phase in ACTIVE. Deasserted on the phase_done edge.
- pending and busy reflect state after each edge.

## Test plan
- Round-robin order: hold sensor=5'b10101; ready always 1; phase_done pulse 3 cycles after each accept. Required: grants 0, 2, 4, 0; pending[0] re-sets only while the sensor stays high outside ACTIVE phase 0.
- Offer stability: sensor[3] pulse, then grant_ready=0 for 6 cycles while preempt=1, preempt_phase=1. Required: grant_phase stays 3, grant_valid stays 1, abort 0; on ready, phase 3 is accepted; after phase_done, phase 1 is offered next.
- Preempt abort: phase 2 ACTIVE; preempt=1, preempt_phase=4 for 1 cycle. Required: abort=1 on the next edge and held until phase_done; the next grant is 4 while preempt is held, otherwise round-robin from 3.
- Invalid preempt: preempt=1, preempt_phase=6, no sensors. Required: stays IDLE, grant_valid=0, abort=0.
- Set/clear collision: sensor[1] high on the accept edge of phase 1. Required: pending[1]=0 after that edge, and stays 0 while ACTIVE phase 1.
- Reset mid-ACTIVE with abort=1 and pending=5'b11000. Required: all outputs 0 asynchronously; after release with sensor=0 the block stays IDLE.

Source files
------------

// File: rtl/tlc_phase_arbiter_if.sv
// Grant handshake between the phase arbiter and the light sequencer.
interface tlc_phase_arbiter_if #(
  parameter int PW = 3
) ();
  logic          grant_valid;
  logic [PW-1:0] grant_phase;
  logic          grant_ready;
  logic          phase_done;
  logic          abort;

  modport master (
    output grant_valid, grant_phase, abort,
    input  grant_ready, phase_done
  );

  modport slave (
    input  grant_valid, grant_phase, abort,
    output grant_ready, phase_done
  );
endinterface

// File: rtl/tlc_phase_arbiter.sv
// Green-phase scheduler: sticky per-phase requests, round-robin pick with
// emergency preemption, one phase handed to the sequencer at a time.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | nothing in flight; picks a phase once a request is present
// OFFER  | grant_phase offered, frozen until the sequencer accepts
// ACTIVE | phase being served; waits for phase_done, may raise abort
module tlc_phase_arbiter #(
  parameter int NPH = 5,
  parameter int PW  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NPH-1:0]         sensor,
  input  logic                   preempt,
  input  logic [PW-1:0]          preempt_phase,
  tlc_phase_arbiter_if.master    bus,
  output logic [NPH-1:0]         pending,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, OFFER, ACTIVE} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  grant_phase_q, grant_phase_d;
  logic [PW-1:0]  last_phase_q, last_phase_d;
  logic           abort_q, abort_d;
  logic [NPH-1:0] pending_q, pending_d;

  logic           pv;
  logic [PW-1:0]  sel;
  logic [PW-1:0]  idx;
  logic [NPH-1:0] gp_onehot;
  logic [NPH-1:0] sensor_mask;
  logic [NPH-1:0] clr;

  // An out-of-range emergency phase is treated as no emergency at all.
  assign pv        = preempt && ({1'b0, preempt_phase} < (PW+1)'(NPH));
  assign gp_onehot = NPH'(1) << grant_phase_q;

  // Round-robin search starts just after the last served phase and ends on it;
  // iterating from the far end lets the nearest hit overwrite earlier ones.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int i = NPH; i >= 1; i--) begin
      idx = PW'((int'(last_phase_q) + i) % NPH);
      if (pending_q[idx]) sel = idx;
    end
    if (pv) sel = preempt_phase;
  end

  // Next-state, grant, abort and pending-update decode.
  always_comb begin
    state_d       = state_q;
    grant_phase_d = grant_phase_q;
    last_phase_d  = last_phase_q;
    abort_d       = abort_q;
    sensor_mask   = sensor;
    clr           = '0;
    case (state_q)
      IDLE: begin
        if (pv || (|pending_q)) begin
          grant_phase_d = sel;
          state_d       = OFFER;
        end
      end
      OFFER: begin
        if (bus.grant_ready) begin
          state_d      = ACTIVE;
          last_phase_d = grant_phase_q;
          clr          = gp_onehot;
        end
      end
      ACTIVE: begin
        // The phase on green does not re-request itself.
        sensor_mask = sensor & ~gp_onehot;
        if (bus.phase_done) begin
          state_d = IDLE;
          abort_d = 1'b0;
        end else if (pv && (preempt_phase != grant_phase_q)) begin
          abort_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Clear wins over a same-cycle set.
    pending_d = (pending_q | sensor_mask) & ~clr;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_phase_q <= '0;
      last_phase_q  <= PW'(NPH - 1);
      abort_q       <= 1'b0;
      pending_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_phase_q <= grant_phase_d;
      last_phase_q  <= last_phase_d;
      abort_q       <= abort_d;
      pending_q     <= pending_d;
    end
  end

  assign bus.grant_valid = (state_q == OFFER);
  assign bus.grant_phase = grant_phase_q;
  assign bus.abort       = abort_q;
  assign pending         = pending_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_tlc_phase_arbiter.sv
// Directed bench for tlc_phase_arbiter with a grant-order scoreboard.
module tb_tlc_phase_arbiter;
  localparam int NPH = 5;
  localparam int PW  = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [NPH-1:0] sensor;
  logic           preempt;
  logic [PW-1:0]  preempt_phase;
  logic [NPH-1:0] pending;
  logic           busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int exp_q[$];

  tlc_phase_arbiter_if #(.PW(PW)) bus ();

  tlc_phase_arbiter #(.NPH(NPH), .PW(PW)) dut (
    .clk           (clk),
    .reset         (reset),
    .sensor        (sensor),
    .preempt       (preempt),
    .preempt_phase (preempt_phase),
    .bus           (bus.master),
    .pending       (pending),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    reset           = 1'b1;
    sensor          = '0;
    preempt         = 1'b0;
    preempt_phase   = '0;
    bus.grant_ready = 1'b0;
    bus.phase_done  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) for an offer, then compare it with the next scoreboard entry.
  task automatic expect_grant(input string tag);
    int n = 0;
    int e;
    while (!bus.grant_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, bus.grant_valid, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    chk({tag, "_phase"}, bus.grant_phase, e);
  endtask

  // Accept the current offer and finish the phase three cycles later.
  task automatic serve();
    bus.grant_ready = 1'b1;
    tick();
    bus.grant_ready = 1'b0;
    tick();
    tick();
    bus.phase_done = 1'b1;
    tick();
    bus.phase_done = 1'b0;
  endtask

  initial begin
    // Reset state
    reset_dut();
    chk("rst_valid", bus.grant_valid, 0);
    chk("rst_phase", bus.grant_phase, 0);
    chk("rst_abort", bus.abort, 0);
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 0);

    // Round-robin with sensors 0,2,4 held high and ready held high
    sensor = 5'b10101;
    bus.grant_ready = 1'b1;
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(0);
    for (int k = 0; k < 4; k++) begin
      expect_grant("rr");
      tick();
      chk("rr_busy", busy, 1);
      chk("rr_active_valid", bus.grant_valid, 0);
      if (k == 0) chk("rr_p0_cleared", pending[0], 0);
      tick();
      if (k == 0) chk("rr_p0_masked", pending[0], 0);
      tick();
      bus.phase_done = 1'b1;
      tick();
      bus.phase_done = 1'b0;
      chk("rr_idle", busy, 0);
      if (k == 0) begin
        chk("rr_p0_done_edge", pending[0], 0);
        tick();
        chk("rr_p0_reset", pending[0], 1);
      end
    end
    bus.grant_ready = 1'b0;
    sensor = '0;

    // Offer stability while a preempt appears during OFFER
    reset_dut();
    sensor = 5'b01000;
    tick();
    sensor = '0;
    exp_q.push_back(3);
    expect_grant("stab");
    preempt = 1'b1;
    preempt_phase = 3'd1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("stab_phase", bus.grant_phase, 3);
      chk("stab_valid", bus.grant_valid, 1);
      chk("stab_abort", bus.abort, 0);
    end
    bus.grant_ready = 1'b1;
    tick();
    bus.grant_ready = 1'b0;
    chk("stab_accept_busy", busy, 1);
    chk("stab_accept_pending", pending, 0);
    chk("stab_accept_abort", bus.abort, 0);
    tick();
    chk("stab_abort_set", bus.abort, 1);
    bus.phase_done = 1'b1;
    tick();
    bus.phase_done = 1'b0;
    chk("stab_abort_clr", bus.abort, 0);
    chk("stab_idle", busy, 0);
    exp_q.push_back(1);
    expect_grant("stab_pre");
    preempt = 1'b0;
    serve();

    // Preempt abort while phase 2 active, then round-robin resumes from 3
    reset_dut();
    sensor = 5'b00100;
    tick();
    sensor = '0;
    exp_q.push_back(2);
    expect_grant("ab");
    bus.grant_ready = 1'b1;
    tick();
    bus.grant_ready = 1'b0;
    preempt = 1'b1;
    preempt_phase = 3'd4;
    tick();
    preempt = 1'b0;
    chk("ab_set", bus.abort, 1);
    sensor = 5'b11001;
    tick();
    sensor = '0;
    chk("ab_hold1", bus.abort, 1);
    chk("ab_pending", pending, 5'b11001);
    tick();
    chk("ab_hold2", bus.abort, 1);
    bus.phase_done = 1'b1;
    tick();
    bus.phase_done = 1'b0;
    chk("ab_clr", bus.abort, 0);
    exp_q.push_back(3);
    expect_grant("ab_rr");
    serve();
    exp_q.push_back(4);
    expect_grant("ab_rr");
    bus.grant_ready = 1'b1;
    tick();
    bus.grant_ready = 1'b0;
    preempt = 1'b1;
    preempt_phase = 3'd4;
    tick();
    chk("ab_same_phase", bus.abort, 0);
    tick();
    chk("ab_same_phase", bus.abort, 0);
    bus.phase_done = 1'b1;
    tick();
    bus.phase_done = 1'b0;
    exp_q.push_back(4);
    expect_grant("ab_pre_wins");
    preempt = 1'b0;
    serve();
    exp_q.push_back(0);
    expect_grant("ab_rr");
    serve();
    chk("ab_pending_empty", pending, 0);

    // Invalid preempt phases are ignored
    reset_dut();
    preempt = 1'b1;
    preempt_phase = 3'd6;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("inv_valid", bus.grant_valid, 0);
      chk("inv_busy", busy, 0);
      chk("inv_abort", bus.abort, 0);
    end
    preempt_phase = 3'd5;
    tick();
    tick();
    chk("inv5_valid", bus.grant_valid, 0);
    preempt_phase = 3'd7;
    tick();
    chk("inv7_busy", busy, 0);
    preempt = 1'b0;

    // Set/clear collision on the accept edge of phase 1
    reset_dut();
    sensor = 5'b00010;
    tick();
    sensor = '0;
    exp_q.push_back(1);
    expect_grant("coll");
    sensor = 5'b00010;
    bus.grant_ready = 1'b1;
    tick();
    bus.grant_ready = 1'b0;
    chk("coll_clear_wins", pending[1], 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("coll_masked", pending[1], 0);
    end
    sensor = '0;
    bus.phase_done = 1'b1;
    tick();
    bus.phase_done = 1'b0;
    chk("coll_pending", pending, 0);
    tick();
    chk("coll_idle_busy", busy, 0);
    chk("coll_idle_valid", bus.grant_valid, 0);

    // Asynchronous reset in ACTIVE with abort and pending set
    reset_dut();
    sensor = 5'b00100;
    tick();
    sensor = '0;
    exp_q.push_back(2);
    expect_grant("ar");
    bus.grant_ready = 1'b1;
    tick();
    bus.grant_ready = 1'b0;
    sensor = 5'b11000;
    preempt = 1'b1;
    preempt_phase = 3'd3;
    tick();
    sensor = '0;
    preempt = 1'b0;
    chk("ar_pre_abort", bus.abort, 1);
    chk("ar_pre_pending", pending, 5'b11000);
    chk("ar_pre_phase", bus.grant_phase, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", bus.grant_valid, 0);
    chk("ar_phase", bus.grant_phase, 0);
    chk("ar_abort", bus.abort, 0);
    chk("ar_pending", pending, 0);
    chk("ar_busy", busy, 0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ar_post_valid", bus.grant_valid, 0);
      chk("ar_post_busy", busy, 0);
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
